fpu_addsub_sequencer: RTL and testbench

FPU_ADDSUB_SEQUENCER -- requirements
Module: fpu_addsub_sequencer

---
 rtl/fpu_addsub_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fpu_addsub_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_sequencer.sv
// fpu_addsub_sequencer
//   Arbitrates two requesters onto one fixed-latency add/sub/compare unit and
//   returns one response at a time with valid/ready handshaking.
//
//   Optional feature macro: FPU_ADDSUB_COND_CODES_EN
//     defined   -> rsp_cc captures {C3=equal, C2=0, C1=0, C0=less}
//     undefined -> rsp_cc is constant 0000, no condition-code logic built
//
//   Ports
//     clk, reset                  clock, async active-high reset
//     reqN_valid/op/a/b/ready     requester N (N=0,1); op 00 ADD 01 SUB 10 CMP 11 reserved
//     rsp_valid/ready             response handshake
//     rsp_id                      requester that owns the response
//     rsp_result, rsp_*flags      captured unit result and compare flags
//     rsp_cc, rsp_err             condition code, reserved-opcode flag
//     unit_operand_a/b, invert_b  registered drive to the unit
//     unit_result, unit_cmp_*     unit outputs, valid UNIT_LATENCY cycles after launch
//     busy                        high whenever not IDLE
module fpu_addsub_sequencer #(
    parameter int unsigned UNIT_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [79:0] req0_a,
    input  logic [79:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [79:0] req1_a,
    input  logic [79:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [79:0] rsp_result,
    output logic        rsp_equal,
    output logic        rsp_less,
    output logic        rsp_greater,
    output logic [3:0]  rsp_cc,
    output logic        rsp_err,
    output logic [79:0] unit_operand_a,
    output logic [79:0] unit_operand_b,
    output logic        unit_invert_b,
    input  logic [79:0] unit_result,
    input  logic        unit_cmp_equal,
    input  logic        unit_cmp_less,
    input  logic        unit_cmp_greater,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [3:0] CNT_LAST = 4'(UNIT_LATENCY - 1);

    state_t      state_q;
    logic        rr_q;        // requester favoured when both are valid
    logic [3:0]  cnt_q;
    logic        err_q;       // reserved opcode in flight: skip the unit wait
    logic        id_q;
    logic        rsp_valid_q, rsp_id_q, rsp_err_q;
    logic        rsp_eq_q, rsp_lt_q, rsp_gt_q;
    logic [79:0] rsp_result_q;
    logic [79:0] opa_q, opb_q;
    logic        inv_q;

    logic        grant_id;
    logic        any_req;
    logic [1:0]  sel_op;
    logic [79:0] sel_a, sel_b;

    // Single valid requester wins outright; contention resolved by rr_q.
    assign grant_id = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign any_req  = req0_valid || req1_valid;
    assign sel_op   = grant_id ? req1_op : req0_op;
    assign sel_a    = grant_id ? req1_a  : req0_a;
    assign sel_b    = grant_id ? req1_b  : req0_b;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign req0_ready = !reset && (state_q == IDLE) && req0_valid && !grant_id;
    assign req1_ready = !reset && (state_q == IDLE) && req1_valid &&  grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_result_q <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            inv_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        rr_q    <= ~grant_id;
                        id_q    <= grant_id;
                        opa_q   <= sel_a;
                        opb_q   <= sel_b;
                        inv_q   <= (sel_op == OP_SUB);
                        err_q   <= (sel_op == OP_RSV);
                        cnt_q   <= 4'd0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (err_q) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= id_q;
                        rsp_err_q    <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_eq_q     <= 1'b0;
                        rsp_lt_q     <= 1'b0;
                        rsp_gt_q     <= 1'b0;
                        state_q      <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= id_q;
                        rsp_err_q    <= 1'b0;
                        rsp_result_q <= unit_result;
                        rsp_eq_q     <= unit_cmp_equal;
                        rsp_lt_q     <= unit_cmp_less;
                        rsp_gt_q     <= unit_cmp_greater;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FPU_ADDSUB_COND_CODES_EN
    logic [3:0] cc_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q <= 4'd0;
        end else if (state_q == EXEC) begin
            if (err_q)
                cc_q <= 4'd0;
            else if (cnt_q == CNT_LAST)
                cc_q <= {unit_cmp_equal, 2'b00, unit_cmp_less};
        end
    end
    assign rsp_cc = cc_q;
`else
    assign rsp_cc = 4'd0;
`endif

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_equal      = rsp_eq_q;
    assign rsp_less       = rsp_lt_q;
    assign rsp_greater    = rsp_gt_q;
    assign rsp_err        = rsp_err_q;
    assign unit_operand_a = opa_q;
    assign unit_operand_b = opb_q;
    assign unit_invert_b  = inv_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Directed bench for fpu_addsub_sequencer (UNIT_LATENCY = 2). The bench plays
// the unit itself by driving unit_result / unit_cmp_* with known values.
module tb_fpu_addsub_sequencer;

    localparam logic [79:0] POS1 = 80'h3FFF8000000000000000;
    localparam logic [79:0] NEG1 = 80'hBFFF8000000000000000;
    localparam logic [79:0] TWO  = 80'h40008000000000000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic [1:0]  req0_op = 0, req1_op = 0;
    logic [79:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_equal, rsp_less, rsp_greater, rsp_err;
    logic        rsp_ready = 0;
    logic [79:0] rsp_result;
    logic [3:0]  rsp_cc;
    logic [79:0] unit_operand_a, unit_operand_b;
    logic        unit_invert_b;
    logic [79:0] unit_result = 0;
    logic        unit_cmp_equal = 0, unit_cmp_less = 0, unit_cmp_greater = 0;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    fpu_addsub_sequencer #(.UNIT_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_equal(rsp_equal), .rsp_less(rsp_less), .rsp_greater(rsp_greater),
        .rsp_cc(rsp_cc), .rsp_err(rsp_err),
        .unit_operand_a(unit_operand_a), .unit_operand_b(unit_operand_b), .unit_invert_b(unit_invert_b),
        .unit_result(unit_result), .unit_cmp_equal(unit_cmp_equal), .unit_cmp_less(unit_cmp_less),
        .unit_cmp_greater(unit_cmp_greater), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present one request, let it be accepted, then count edges until rsp_valid.
    task automatic send(input bit id, input logic [1:0] op, input logic [79:0] a, input logic [79:0] b,
                        output bit rdy, output int lat);
        @(negedge clk);
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        #1;
        rdy = id ? req1_ready : req0_ready;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_rsp();
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        req0_valid = 1; req1_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, rsp_valid, req0_ready, req1_ready, rsp_err, rsp_cc} !== 9'b0)
            $display("FAIL reset_ctl: busy/valid/rdy0/rdy1/err/cc=%b required 0", {busy, rsp_valid, req0_ready, req1_ready, rsp_err, rsp_cc});
        else pass_cnt++;
        total_cnt++;
        if ({unit_operand_a, unit_operand_b, rsp_result, unit_invert_b} !== 241'b0)
            $display("FAIL reset_data: operands/result nonzero");
        else pass_cnt++;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_round_robin();
        logic [1:0] ops0 [0:1];
        logic [1:0] ops1 [0:1];
        int i0, i1, n, lat;
        bit g, exp_inv;
        ops0[0] = 2'd0; ops0[1] = 2'd1;
        ops1[0] = 2'd1; ops1[1] = 2'd2;
        i0 = 0; i1 = 0;
        @(negedge clk);
        req0_valid = 1; req0_op = ops0[0]; req0_a = POS1; req0_b = POS1;
        req1_valid = 1; req1_op = ops1[0]; req1_a = NEG1; req1_b = POS1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin @(posedge clk); #1; n++; end
            g = req1_ready;
            total_cnt++;
            if (!(req0_ready || req1_ready) || g !== k[0])
                $display("FAIL rr_grant[%0d]: got rdy0=%b rdy1=%b required grant %0d", k, req0_ready, req1_ready, k % 2);
            else pass_cnt++;
            exp_inv = ((g ? ops1[i1] : ops0[i0]) == 2'd1);
            @(posedge clk); #1;
            total_cnt++;
            if (unit_invert_b !== exp_inv)
                $display("FAIL rr_invert[%0d]: got %b required %b", k, unit_invert_b, exp_inv);
            else pass_cnt++;
            if (!g) begin
                i0++;
                if (i0 == 2) req0_valid = 0; else req0_op = ops0[i0];
            end else begin
                i1++;
                if (i1 == 2) req1_valid = 0; else req1_op = ops1[i1];
            end
            lat = 0;
            while (!rsp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
            total_cnt++;
            if (!rsp_valid || rsp_id !== g)
                $display("FAIL rr_rsp_id[%0d]: got valid=%b id=%b required id %b", k, rsp_valid, rsp_id, g);
            else pass_cnt++;
            release_rsp();
        end
    endtask

    task automatic test_add();
        bit rdy; int lat;
        unit_result = TWO; unit_cmp_equal = 0; unit_cmp_less = 0; unit_cmp_greater = 0;
        send(0, 2'd0, POS1, POS1, rdy, lat);
        total_cnt++;
        if (rdy !== 1'b1 || lat != 2) $display("FAIL add_latency: ready=%b latency=%0d required 1/2", rdy, lat);
        else pass_cnt++;
        total_cnt++;
        if (rsp_id !== 1'b0 || rsp_err !== 1'b0) $display("FAIL add_id: id=%b err=%b required 0/0", rsp_id, rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (rsp_result !== TWO) $display("FAIL add_result: got %h required %h", rsp_result, TWO);
        else pass_cnt++;
        total_cnt++;
        if (unit_operand_a !== POS1 || unit_operand_b !== POS1 || unit_invert_b !== 1'b0)
            $display("FAIL add_operands: a=%h b=%h inv=%b", unit_operand_a, unit_operand_b, unit_invert_b);
        else pass_cnt++;
        release_rsp();
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_release: valid=%b busy=%b required 0/0", rsp_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_cmp();
        bit rdy; int lat;
        logic [3:0] exp_cc;
`ifdef FPU_ADDSUB_COND_CODES_EN
        exp_cc = 4'b0001;
`else
        exp_cc = 4'b0000;
`endif
        unit_result = 80'h1234; unit_cmp_equal = 0; unit_cmp_less = 0; unit_cmp_greater = 1;
        send(1, 2'd2, POS1, NEG1, rdy, lat);
        total_cnt++;
        if (rdy !== 1'b1 || lat != 2 || rsp_id !== 1'b1)
            $display("FAIL cmp_gt_hs: ready=%b latency=%0d id=%b required 1/2/1", rdy, lat, rsp_id);
        else pass_cnt++;
        total_cnt++;
        if ({rsp_equal, rsp_less, rsp_greater} !== 3'b001 || rsp_cc !== 4'b0000 || rsp_result !== 80'h1234)
            $display("FAIL cmp_gt: flags=%b cc=%b result=%h required 001/0000/1234", {rsp_equal, rsp_less, rsp_greater}, rsp_cc, rsp_result);
        else pass_cnt++;
        release_rsp();
        unit_result = 80'h5678; unit_cmp_less = 1; unit_cmp_greater = 0;
        send(1, 2'd2, NEG1, POS1, rdy, lat);
        total_cnt++;
        if ({rsp_equal, rsp_less, rsp_greater} !== 3'b010 || rsp_result !== 80'h5678 || unit_invert_b !== 1'b0)
            $display("FAIL cmp_lt: flags=%b result=%h inv=%b required 010/5678/0", {rsp_equal, rsp_less, rsp_greater}, rsp_result, unit_invert_b);
        else pass_cnt++;
        total_cnt++;
        if (rsp_cc !== exp_cc) $display("FAIL cmp_lt_cc: got %b required %b", rsp_cc, exp_cc);
        else pass_cnt++;
        release_rsp();
        unit_cmp_less = 0;
    endtask

    task automatic test_stall();
        bit rdy; int lat;
        unit_result = 80'hABCD; unit_cmp_equal = 1; unit_cmp_less = 0; unit_cmp_greater = 0;
        send(0, 2'd0, POS1, NEG1, rdy, lat);
        total_cnt++;
        if (!rsp_valid || rsp_result !== 80'hABCD) $display("FAIL stall_capture: valid=%b result=%h required 1/abcd", rsp_valid, rsp_result);
        else pass_cnt++;
        unit_result = 80'h9999; unit_cmp_equal = 0; unit_cmp_greater = 1;
        req1_valid = 1; req1_op = 2'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_result !== 80'hABCD || {rsp_equal, rsp_less, rsp_greater} !== 3'b100 ||
                rsp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL stall_hold[%0d]: valid=%b result=%h flags=%b id=%b rdy=%b%b busy=%b", c,
                         rsp_valid, rsp_result, {rsp_equal, rsp_less, rsp_greater}, rsp_id, req0_ready, req1_ready, busy);
            else pass_cnt++;
        end
        req1_valid = 0;
        release_rsp();
        unit_cmp_greater = 0;
    endtask

    task automatic test_reserved();
        bit rdy; int lat;
        unit_result = 80'hFFFF; unit_cmp_equal = 1; unit_cmp_less = 1; unit_cmp_greater = 1;
        send(0, 2'd3, POS1, POS1, rdy, lat);
        total_cnt++;
        if (rdy !== 1'b1 || lat != 1) $display("FAIL rsv_latency: ready=%b latency=%0d required 1/1", rdy, lat);
        else pass_cnt++;
        total_cnt++;
        if (rsp_err !== 1'b1 || rsp_result !== 80'h0 || {rsp_equal, rsp_less, rsp_greater} !== 3'b000 || rsp_cc !== 4'b0)
            $display("FAIL rsv_payload: err=%b result=%h flags=%b cc=%b required 1/0/000/0000",
                     rsp_err, rsp_result, {rsp_equal, rsp_less, rsp_greater}, rsp_cc);
        else pass_cnt++;
        release_rsp();
        unit_cmp_equal = 0; unit_cmp_less = 0; unit_cmp_greater = 0;
    endtask

    task automatic test_reset_mid_exec();
        int lat; bit seen;
        unit_result = TWO;
        @(negedge clk);
        req0_valid = 1; req0_op = 2'd0; req0_a = POS1; req0_b = POS1;
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        reset = 1;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || unit_operand_a !== 80'h0)
            $display("FAIL rst_exec: busy=%b valid=%b opa=%h required 0/0/0", busy, rsp_valid, unit_operand_a);
        else pass_cnt++;
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
        total_cnt++;
        if (seen) $display("FAIL rst_no_rsp: rsp_valid seen after reset, required none");
        else pass_cnt++;
        @(negedge clk);
        req0_valid = 1; req0_op = 2'd0; req1_valid = 1; req1_op = 2'd1;
        #1;
        total_cnt++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL rst_pointer: rdy0=%b rdy1=%b required 1/0", req0_ready, req1_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
        total_cnt++;
        if (lat != 2 || rsp_id !== 1'b0 || rsp_result !== TWO)
            $display("FAIL rst_resume: latency=%0d id=%b result=%h required 2/0/%h", lat, rsp_id, rsp_result, TWO);
        else pass_cnt++;
        release_rsp();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_add();
        test_cmp();
        test_stall();
        test_reserved();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
